video_out_load: RTL and testbench

//  Wishbone read master for the video output path: fetches one frame at a time from RAM
//  (start address supplied by the processor) and pushes it, one 32-bit word per read,

---
 rtl/video_out_load.sv | 126 ++++++++++++
 tb/tb_video_out_load.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_out_load.sv
// rtl/video_out_load.sv - Wishbone read master streaming one frame from RAM into the video-out FIFO
module video_out_load #(
  parameter int p_WIDTH      = 640,
  parameter int p_HEIGHT     = 480,
  parameter int NB_PACK_LOAD = 16,
  parameter int INT_CYCLES   = 3
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] wb_reg_ctr,
  input  logic [31:0] wb_reg_data,
  input  logic        fifo_space,
  output logic        w_req,
  output logic [31:0] data_to_fifo,
  output logic        interrupt,
  output logic        new_addr,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [31:0] p_wb_ADR_O,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I
);

  localparam int BC_W = $clog2(NB_PACK_LOAD + 1);
  localparam int IC_W = $clog2(INT_CYCLES + 1);
  localparam logic [19:0]     FRAME_BYTES = 20'(p_WIDTH * p_HEIGHT);
  localparam logic [BC_W-1:0] BURST_INIT  = BC_W'(NB_PACK_LOAD);
  localparam logic [IC_W-1:0] INT_LAST    = IC_W'(INT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_ADDR,
    WAIT_SPACE,
    READ,
    WAIT_ACK,
    BREAK,
    IMAGE_DONE
  } state_t;

  state_t          state;
  logic            old_ctr0;
  logic [31:0]     deb_im;
  logic [19:0]     byte_cnt;
  logic [BC_W-1:0] burst_cnt;
  logic [IC_W-1:0] int_cnt;
  logic            ctr_unused;

  // Only bit 0 of the control register carries meaning for this block.
  assign ctr_unused  = ^wb_reg_ctr[31:1];
  assign new_addr    = wb_reg_ctr[0] & ~old_ctr0;
  assign p_wb_SEL_O  = 4'hF;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_WE_O   = 1'b0;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) old_ctr0 <= 1'b0;
    else       old_ctr0 <= wb_reg_ctr[0];
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state        <= WAIT_ADDR;
      p_wb_STB_O   <= 1'b0;
      p_wb_CYC_O   <= 1'b0;
      p_wb_ADR_O   <= 32'd0;
      w_req        <= 1'b0;
      data_to_fifo <= 32'd0;
      interrupt    <= 1'b0;
      deb_im       <= 32'd0;
      byte_cnt     <= 20'd0;
      burst_cnt    <= BURST_INIT;
      int_cnt      <= '0;
    end else begin
      w_req <= 1'b0;
      case (state)
        WAIT_ADDR: begin
          deb_im    <= wb_reg_data;
          interrupt <= 1'b0;
          byte_cnt  <= 20'd0;
          if (new_addr) state <= WAIT_SPACE;
        end
        WAIT_SPACE: begin
          burst_cnt <= BURST_INIT;
          if (fifo_space) state <= READ;
        end
        READ: begin
          p_wb_ADR_O <= deb_im + {12'd0, byte_cnt};
          p_wb_STB_O <= 1'b1;
          p_wb_CYC_O <= 1'b1;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An errored read still produces a (zero) word so the frame geometry stays intact.
          if (p_wb_ACK_I || p_wb_ERR_I) begin
            data_to_fifo <= p_wb_ACK_I ? p_wb_DAT_I : 32'd0;
            w_req        <= 1'b1;
            p_wb_STB_O   <= 1'b0;
            p_wb_CYC_O   <= 1'b0;
            byte_cnt     <= byte_cnt + 20'd4;
            burst_cnt    <= burst_cnt - BC_W'(1);
            state        <= BREAK;
          end
        end
        BREAK: begin
          if (byte_cnt == FRAME_BYTES) state <= IMAGE_DONE;
          else if (burst_cnt == '0)    state <= WAIT_SPACE;
          else                         state <= READ;
        end
        IMAGE_DONE: begin
          interrupt <= 1'b1;
          if (int_cnt == INT_LAST) begin
            int_cnt <= '0;
            state   <= WAIT_ADDR;
          end else begin
            int_cnt <= int_cnt + IC_W'(1);
          end
        end
        default: state <= WAIT_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_video_out_load.sv
// tb/tb_video_out_load.sv - scoreboard bench for video_out_load with a randomized Wishbone slave
module tb_video_out_load;

  localparam int W   = 8;
  localparam int H   = 2;
  localparam int NB  = 2;
  localparam int IC  = 3;
  localparam int FW  = W * H / 4;

  logic        clk = 1'b0;
  logic        nRST;
  logic [31:0] wb_reg_ctr, wb_reg_data;
  logic        fifo_space;
  logic        w_req, interrupt, new_addr;
  logic [31:0] data_to_fifo;
  logic        stb, cyc, lock, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack_i, err_i;

  video_out_load #(.p_WIDTH(W), .p_HEIGHT(H), .NB_PACK_LOAD(NB), .INT_CYCLES(IC)) dut (
    .clk(clk), .nRST(nRST), .wb_reg_ctr(wb_reg_ctr), .wb_reg_data(wb_reg_data),
    .fifo_space(fifo_space), .w_req(w_req), .data_to_fifo(data_to_fifo),
    .interrupt(interrupt), .new_addr(new_addr),
    .p_wb_STB_O(stb), .p_wb_CYC_O(cyc), .p_wb_LOCK_O(lock), .p_wb_WE_O(we),
    .p_wb_SEL_O(sel), .p_wb_ADR_O(adr), .p_wb_DAT_I(dat_i),
    .p_wb_ACK_I(ack_i), .p_wb_ERR_I(err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
    bit          err;
    bit          both;
  } word_t;

  word_t       bus_q[$];
  logic [31:0] fifo_q[$];
  int n_vec = 0, n_miss = 0;
  int wcount = 0, frames_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // mode 0: data A0+i, immediate ack; mode 1: ack after 5 cycles; mode 2: random data/latency/errors
  task automatic plan_frame(input logic [31:0] base, input int mode, input int err_word);
    for (int i = 0; i < FW; i++) begin
      word_t w;
      w.addr  = base + 32'(4 * i);
      w.data  = (mode == 2) ? $urandom : 32'hA0 + 32'(i);
      w.delay = (mode == 0) ? 0 : (mode == 1) ? 5 : int'($urandom_range(0, 4));
      w.err   = (i == err_word) || (mode == 2 && $urandom_range(0, 4) == 0);
      w.both  = w.err && mode == 2 && $urandom_range(0, 2) == 0;
      bus_q.push_back(w);
      fifo_q.push_back((w.err && !w.both) ? 32'd0 : w.data);
    end
  endtask

  task automatic start_frame(input logic [31:0] base);
    wb_reg_data = base;
    wb_reg_ctr[31:1] = 31'($urandom);
    @(negedge clk);
    chk("new_addr_idle", new_addr, 0);
    wb_reg_ctr[0] = 1'b1;
    #1 chk("new_addr_pulse", new_addr, 1);
    @(negedge clk);
    chk("new_addr_one_cycle", new_addr, 0);
    wb_reg_data = $urandom;
    wb_reg_ctr[0] = 1'b0;
  endtask

  task automatic finish_frame(input bit gate, input bit repulse, input bit rnd);
    int start, f0;
    bit done;
    start = wcount;
    f0 = frames_done;
    done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rnd) fifo_space = ($urandom_range(0, 3) != 0);
      if (gate && wcount >= start + NB) begin
        gate = 0;
        fifo_space = 1'b0;
        repeat (20) begin
          @(negedge clk);
          chk("no_stb_while_full", stb, 0);
        end
        fifo_space = 1'b1;
      end
      if (repulse && wcount >= start + 1) begin
        repulse = 0;
        wb_reg_data = $urandom;
        wb_reg_ctr[0] = 1'b1;
        @(negedge clk);
        wb_reg_ctr[0] = 1'b0;
      end
      if (frames_done > f0) begin
        done = 1;
        break;
      end
    end
    fifo_space = 1'b1;
    chk("frame_done_in_time", 32'(done), 1);
  endtask

  // Wishbone slave: serves planned reads in order and checks the bus while waiting.
  initial begin
    word_t w;
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = 32'd0;
    forever begin
      @(negedge clk);
      if (nRST && stb) begin
        if (bus_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_read: got read at %h expected no read", adr);
          ack_i = 1'b1;
          @(negedge clk);
          ack_i = 1'b0;
        end else begin
          w = bus_q.pop_front();
          chk("rd_addr", adr, w.addr);
          chk("rd_cyc", cyc, 1);
          chk("rd_we", we, 0);
          chk("rd_lock", lock, 0);
          chk("rd_sel", sel, 4'hF);
          for (int i = 0; i < w.delay; i++) begin
            @(negedge clk);
            if (!nRST) break;
            chk("stb_held", stb, 1);
            chk("cyc_held", cyc, 1);
            chk("adr_held", adr, w.addr);
            chk("no_wreq_before_ack", w_req, 0);
          end
          if (nRST) begin
            ack_i = !w.err || w.both;
            err_i = w.err;
            dat_i = w.data;
            @(negedge clk);
            ack_i = 1'b0;
            err_i = 1'b0;
            dat_i = $urandom;
          end
        end
      end
    end
  end

  // FIFO-side monitor
  initial begin
    forever begin
      @(negedge clk);
      if (w_req) begin
        wcount++;
        if (fifo_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL spurious_wreq: got word %h expected none", data_to_fifo);
        end else begin
          chk("fifo_data", data_to_fifo, fifo_q.pop_front());
        end
      end
    end
  end

  // Interrupt monitor: pulse width and frame completeness
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (interrupt) begin
        run++;
        if (run == 1) chk("words_before_irq", 32'(fifo_q.size() + bus_q.size()), 0);
      end else if (run > 0) begin
        chk("irq_len", 32'(run), IC);
        frames_done++;
        run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    nRST = 1'b1;
    wb_reg_ctr = 32'd0;
    wb_reg_data = 32'd0;
    fifo_space = 1'b1;
    #3 nRST = 1'b0;
    #1;
    chk("rst_stb", stb, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_lock", lock, 0);
    chk("rst_we", we, 0);
    chk("rst_sel", sel, 4'hF);
    chk("rst_adr", adr, 0);
    chk("rst_wreq", w_req, 0);
    chk("rst_data", data_to_fifo, 0);
    chk("rst_irq", interrupt, 0);
    chk("rst_new_addr", new_addr, 0);
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_no_stb", stb, 0);
    end

    plan_frame(32'h1000, 0, -1);  start_frame(32'h1000); finish_frame(0, 0, 0);
    plan_frame(32'h1000, 0, -1);  start_frame(32'h1000); finish_frame(1, 0, 0);
    plan_frame(32'h2000, 1, -1);  start_frame(32'h2000); finish_frame(0, 0, 0);
    plan_frame(32'h1000, 0, 1);   start_frame(32'h1000); finish_frame(0, 0, 0);
    plan_frame(32'h3000, 2, -1);  start_frame(32'h3000); finish_frame(0, 1, 0);
    plan_frame(32'hFFFF_FFF8, 2, -1); start_frame(32'hFFFF_FFF8); finish_frame(0, 0, 1);

    for (int f = 0; f < 12; f++) begin
      logic [31:0] base;
      base = $urandom;
      plan_frame(base, 2, -1);
      start_frame(base);
      finish_frame(0, ($urandom_range(0, 2) == 0), 1);
    end

    // Reset while a read is outstanding must drop the bus immediately.
    plan_frame(32'h4000, 0, -1);
    bus_q[0].delay = 8;
    start_frame(32'h4000);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (stb) begin
        seen = 1;
        break;
      end
    end
    chk("stb_before_reset", 32'(seen), 1);
    repeat (3) @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_stb", stb, 0);
    chk("midrst_cyc", cyc, 0);
    chk("midrst_wreq", w_req, 0);
    chk("midrst_adr", adr, 0);
    repeat (2) @(negedge clk);
    bus_q.delete();
    fifo_q.delete();
    nRST = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", stb, 0);
    end
    plan_frame(32'h5000, 2, -1); start_frame(32'h5000); finish_frame(0, 0, 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
